// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (I)
// and data access (D); one access in flight, fixed read latency, one-cycle ack pulse.
module mem_port_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AWIDTH  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_ack,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [2:0]        d_we,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_en,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [2:0]        mem_we,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]      r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_owner, w_owner;
  logic            r_last, w_last;
  logic            r_wr, w_wr;
  logic            r_i_ack, w_i_ack;
  logic            r_d_ack, w_d_ack;
  logic [XLEN-1:0] r_i_rdata, w_i_rdata;
  logic [XLEN-1:0] r_d_rdata, w_d_rdata;
  logic            r_mem_en, w_mem_en;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata;
  logic [2:0]      r_mem_we, w_mem_we;

  // Next-state and next-output logic; every output is the registered copy of a w_ value
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_owner     = r_owner;
    w_last      = r_last;
    w_wr        = r_wr;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_mem_en    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_we    = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the requester that did not win last time gets the port
          w_owner  = (i_req && d_req) ? ~r_last : d_req;
          w_last   = w_owner;
          w_state  = S_ISSUE;
          w_mem_en = 1'b1;
          if (w_owner == OWN_D) begin
            w_mem_addr  = d_addr;
            w_mem_wdata = d_wdata;
            w_mem_we    = d_we;
            w_wr        = |d_we;
          end else begin
            w_mem_addr  = XLEN'(i_addr);
            w_mem_wdata = '0;
            w_mem_we    = 3'b000;
            w_wr        = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        w_cnt   = CW'(MEM_LAT);
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_cnt   = '0;
          w_state = S_ACK;
          w_i_ack = (r_owner == OWN_I);
          w_d_ack = (r_owner == OWN_D);
          if (r_owner == OWN_I) w_i_rdata = mem_rdata;
          else if (!r_wr)       w_d_rdata = mem_rdata;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_ACK: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= OWN_I;
      r_last      <= OWN_I;
      r_wr        <= 1'b0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 3'b000;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_wr        <= w_wr;
      r_i_ack     <= w_i_ack;
      r_d_ack     <= w_d_ack;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_mem_en    <= w_mem_en;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule
